// File: rtl/dm_pkg.sv
// Shared types, widths and the byte-merge helper for the data-memory responder.
package dm_pkg;

    localparam int unsigned DEPTH_WORDS_DEF = 3072;
    localparam int unsigned WORD_IDX_W      = $clog2(DEPTH_WORDS_DEF);
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Replace each byte lane of old_w whose enable is set with the lane from new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        for (int i = 0; i < int'(BE_W); i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised data storage: byte-enabled synchronous write, combinational read,
// synchronous clear of every word on reset.
module dm_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [WORD_IDX_W-1:0] i_idx,
    input  logic [BE_W-1:0]       i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic              w_idx_ok;

    assign w_idx_ok  = {1'b0, i_idx} < (WORD_IDX_W+1)'(DEPTH_WORDS);
    assign o_rdata_c = w_idx_ok ? r_mem[i_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_idx_ok) begin
            r_mem[i_idx] <= merge_bytes(r_mem[i_idx], i_wdata, i_be);
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, programmable wait states.
// Define DM_WRITE_LOG_EN to print a line for every in-range store that changes bytes.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

    dm_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [BE_W-1:0]    r_be;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;

    logic [31:0]        w_off;
    logic               w_in_range;
    logic               w_access;
    logic               w_wr_en;
    logic [DATA_W-1:0]  w_rd;
    logic [DATA_W-1:0]  w_merged;

    // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both bounds.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = w_off < SPAN_BYTES;
    assign w_access   = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_wr_en    = w_access && r_we && w_in_range && (r_be != '0);
    assign w_merged   = merge_bytes(w_rd, r_wdata, r_be);

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_wr_en),
        .i_idx     (w_off[WORD_IDX_W+1:2]),
        .i_be      (r_be),
        .i_wdata   (r_wdata),
        .o_rdata_c (w_rd)
    );

`ifdef DM_WRITE_LOG_EN
    logic [31:0] r_pc;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

    // Request FSM; the memory access happens on the edge that leaves BUSY with the counter at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef DM_WRITE_LOG_EN
            r_pc        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_be        <= req_be;
                        r_wdata     <= req_wdata;
`ifdef DM_WRITE_LOG_EN
                        r_pc        <= req_pc;
`endif
                        r_cnt       <= CNT_W'(WAIT_CYCLES);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ~w_in_range;
                        r_rsp_rdata <= w_in_range ? (r_we ? w_merged : w_rd) : '0;
`ifdef DM_WRITE_LOG_EN
                        if (w_wr_en) begin
                            $display("@%08h: *%08h <= %08h", r_pc, {r_addr[31:2], 2'b00}, w_merged);
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with two wait states, one with none.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  vld;
    logic [1:0]  rrdy;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;

    logic        rdy_a, rspv_a, err_a;
    logic        rdy_z, rspv_z, err_z;
    logic [31:0] rd_a, rd_z;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(3072), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy_a), .req_we(we),
        .req_addr(addr), .req_be(be), .req_wdata(wdata), .req_pc(pc),
        .rsp_valid(rspv_a), .rsp_ready(rrdy[0]), .rsp_rdata(rd_a), .rsp_err(err_a)
    );

    dm_responder #(.DEPTH_WORDS(3072), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy_z), .req_we(we),
        .req_addr(addr), .req_be(be), .req_wdata(wdata), .req_pc(pc),
        .rsp_valid(rspv_z), .rsp_ready(rrdy[1]), .rsp_rdata(rd_z), .rsp_err(err_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic f_rdy(input int sel);
        return (sel == 0) ? rdy_a : rdy_z;
    endfunction
    function automatic logic f_rspv(input int sel);
        return (sel == 0) ? rspv_a : rspv_z;
    endfunction
    function automatic logic [31:0] f_rd(input int sel);
        return (sel == 0) ? rd_a : rd_z;
    endfunction
    function automatic logic f_err(input int sel);
        return (sel == 0) ? err_a : err_z;
    endfunction

    // Present a request and return #1 after its acceptance edge.
    task automatic send_req(input int sel, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
        int n;
        we = w; addr = a; be = b; wdata = d; pc = 32'h0000_1000 + a;
        vld[sel] = 1'b1;
        n = 0;
        while (!f_rdy(sel) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", 32'(f_rdy(sel)), 32'd1);
        @(posedge clk); #1;
        vld[sel] = 1'b0;
    endtask

    // Count edges from acceptance until rsp_valid is seen.
    task automatic wait_rsp(input int sel, output int lat);
        lat = 0;
        while (!f_rspv(sel) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("rsp_seen", 32'(f_rspv(sel)), 32'd1);
    endtask

    task automatic finish_rsp(input int sel);
        rrdy[sel] = 1'b1;
        @(posedge clk); #1;
        rrdy[sel] = 1'b0;
    endtask

    task automatic xact(input string tag, input int sel, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
        int lat;
        send_req(sel, w, a, b, d);
        wait_rsp(sel, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rd"}, f_rd(sel), exp_rd);
        check({tag, "_err"}, 32'(f_err(sel)), 32'(exp_err));
        finish_rsp(sel);
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        reset = 1'b1; vld = '0; rrdy = '0;
        we = 1'b0; addr = '0; be = '0; wdata = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_rspv", 32'(rspv_a), 32'd0);
        check("rst_rdata", rd_a, 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_ready_w0", 32'(rdy_z), 32'd1);

        xact("st_full", 0, 1'b1, 32'h10, 4'b1111, 32'h1234_5678, 32'h1234_5678, 1'b0, 3);
        check("idle_after_hs", 32'(rdy_a), 32'd1);
        xact("ld_full", 0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h1234_5678, 1'b0, 3);
        xact("st_part", 0, 1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 32'h1234_AB78, 1'b0, 3);
        xact("ld_part", 0, 1'b0, 32'h13, 4'b0000, 32'h0, 32'h1234_AB78, 1'b0, 3);

        // Backpressure: response held while a new request waits.
        send_req(0, 1'b0, 32'h10, 4'b0000, 32'h0);
        wait_rsp(0, lat);
        held = rd_a;
        check("bp_first_rd", held, 32'h1234_AB78);
        we = 1'b0; addr = 32'h10; vld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rspv", 32'(rspv_a), 32'd1);
            check("bp_rdata", rd_a, held);
            check("bp_ready", 32'(rdy_a), 32'd0);
        end
        rrdy[0] = 1'b1;
        @(posedge clk); #1;
        rrdy[0] = 1'b0;
        check("bp_hs_rspv", 32'(rspv_a), 32'd0);
        check("bp_hs_ready", 32'(rdy_a), 32'd1);
        @(posedge clk); #1;
        check("bp_accepted", 32'(rdy_a), 32'd0);
        vld[0] = 1'b0;
        wait_rsp(0, lat);
        check("bp_second_lat", 32'(lat), 32'd3);
        check("bp_second_rd", rd_a, 32'h1234_AB78);
        finish_rsp(0);

        xact("oor_ld", 0, 1'b0, 32'h3000, 4'b0000, 32'h0, 32'h0, 1'b1, 3);
        xact("oor_st", 0, 1'b1, 32'h3000, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1, 3);
        xact("ld_w0_after_oor", 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 3);
        xact("ld_10_after_oor", 0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h1234_AB78, 1'b0, 3);
        xact("st_last", 0, 1'b1, 32'h2FFC, 4'b1111, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 3);
        xact("ld_last", 0, 1'b0, 32'h2FFC, 4'b0000, 32'h0, 32'h55AA_55AA, 1'b0, 3);

        xact("w0_ld", 1, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b0, 1);
        xact("w0_st", 1, 1'b1, 32'h10, 4'b1111, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1);
        xact("w0_st_be0", 1, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b0, 1);
        xact("w0_ld_after", 1, 1'b0, 32'h10, 4'b0000, 32'h0, 32'hA5A5_A5A5, 1'b0, 1);

        // Reset while the store is still counting down.
        send_req(0, 1'b1, 32'h20, 4'b1111, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("mid_busy_rspv", 32'(rspv_a), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_ready", 32'(rdy_a), 32'd1);
        check("mid_rst_rspv", 32'(rspv_a), 32'd0);
        check("mid_rst_rdata", rd_a, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_rsp", 32'(rspv_a), 32'd0);
        xact("ld_20_after_rst", 0, 1'b0, 32'h20, 4'b0000, 32'h0, 32'h0, 1'b0, 3);
        xact("ld_10_after_rst", 0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
